// File: rtl/rgb_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_sequencer
//
// Purpose:
//   Drives a one-hot R/G/B light through programmable per-colour dwell times.
//   Dwell is counted in prescaled ticks. Four run modes are supported:
//     FWD   : R -> G -> B -> R on each dwell expiry
//     REV   : R -> B -> G -> R on each dwell expiry
//     STEP  : advance forward one colour per cycle that step is high
//     BLINK : colour is held, the light blanks/unblanks on each dwell expiry
//   An enable input freezes the whole block. A one-cycle wrap pulse marks
//   every return to RED, for chaining or display-refresh logic.
//
// Parameters:
//   CNT_W    : width of the dwell inputs and the dwell counter
//   PRESCALE : clk cycles per tick (>= 1); 1 gives a tick every clk
//   PS_W     : prescaler counter width, 2**PS_W >= PRESCALE
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   1 = run, 0 = freeze all state (outputs held, wrap low)
//   mode      in   [1:0] 0 FWD, 1 REV, 2 STEP, 3 BLINK
//   step      in   advance request, used in STEP mode only
//   dwell_r   in   [CNT_W-1:0] red dwell in ticks (0 behaves as 1)
//   dwell_g   in   [CNT_W-1:0] green dwell in ticks (0 behaves as 1)
//   dwell_b   in   [CNT_W-1:0] blue dwell in ticks (0 behaves as 1)
//   light     out  [2:0] one-hot {R,G,B}; 000 while blanked
//   color_idx out  [1:0] current colour 0 R, 1 G, 2 B
//   wrap      out  one-cycle pulse after the edge that moves the state to RED
// -----------------------------------------------------------------------------
module rgb_sequencer #(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 1,
  parameter int PS_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [CNT_W-1:0] dwell_r,
  input  logic [CNT_W-1:0] dwell_g,
  input  logic [CNT_W-1:0] dwell_b,
  output logic [2:0]       light,
  output logic [1:0]       color_idx,
  output logic             wrap
);

  typedef enum logic [1:0] {
    ST_RED   = 2'd0,
    ST_GREEN = 2'd1,
    ST_BLUE  = 2'd2
  } color_e;

  typedef enum logic [1:0] {
    MODE_FWD   = 2'd0,
    MODE_REV   = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Registered state and outputs
  color_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             blank_q, blank_d;
  logic [2:0]       light_q, light_d;
  logic [1:0]       color_idx_q, color_idx_d;
  logic             wrap_q, wrap_d;

  // Combinational helpers
  mode_e            mode_s;
  logic             tick;
  logic             expire;
  logic             advance;
  logic [CNT_W-1:0] dwell_sel;
  logic [CNT_W-1:0] dwell_eff;

  assign mode_s = mode_e'(mode);

  // Forward colour order, shared by FWD and STEP.
  function automatic color_e next_fwd(input color_e c);
    case (c)
      ST_RED:   return ST_GREEN;
      ST_GREEN: return ST_BLUE;
      default:  return ST_RED;
    endcase
  endfunction

  // Reverse colour order used by REV.
  function automatic color_e next_rev(input color_e c);
    case (c)
      ST_RED:   return ST_BLUE;
      ST_BLUE:  return ST_GREEN;
      default:  return ST_RED;
    endcase
  endfunction

  // One-hot light pattern for a colour, in {R,G,B} bit order.
  function automatic logic [2:0] one_hot(input color_e c);
    case (c)
      ST_RED:   return 3'b100;
      ST_GREEN: return 3'b010;
      ST_BLUE:  return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  // A tick only exists while running in a timed mode; STEP mode parks the
  // prescaler, so it can never produce one there.
  assign tick = en && (mode_s != MODE_STEP) && (ps_q == PS_LAST);

  // Prescaler: counts 0..PRESCALE-1 and wraps on the tick. Held while
  // frozen and forced to zero in STEP so a later timed mode starts clean.
  always_comb begin
    ps_d = ps_q;
    if (en) begin
      if (mode_s == MODE_STEP) begin
        ps_d = '0;
      end else if (tick) begin
        ps_d = '0;
      end else begin
        ps_d = ps_q + PS_ONE;
      end
    end
  end

  // Dwell for the colour currently shown, read live from the inputs.
  // A programmed zero is treated as one tick so every colour is visible.
  always_comb begin
    case (state_q)
      ST_RED:   dwell_sel = dwell_r;
      ST_GREEN: dwell_sel = dwell_g;
      ST_BLUE:  dwell_sel = dwell_b;
      default:  dwell_sel = dwell_r;
    endcase
    dwell_eff = (dwell_sel == '0) ? CNT_ONE : dwell_sel;
  end

  // Expiry uses >= rather than == so that shrinking the dwell below the
  // running count ends the dwell on the very next tick instead of waiting
  // for the counter to wrap around.
  assign expire = tick && (cnt_q >= (dwell_eff - CNT_ONE));

  // Dwell counter: cleared on expiry and in STEP, advanced on other ticks.
  // A mode change between FWD/REV/BLINK keeps the count.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if ((mode_s == MODE_STEP) || expire) begin
        cnt_d = '0;
      end else if (tick) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Colour state machine. Direction is taken from mode at the moment of
  // expiry; BLINK never moves the colour. advance marks a real colour move
  // so wrap can be derived from it.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_FWD: begin
          if (expire) begin
            state_d = next_fwd(state_q);
            advance = 1'b1;
          end
        end
        MODE_REV: begin
          if (expire) begin
            state_d = next_rev(state_q);
            advance = 1'b1;
          end
        end
        MODE_STEP: begin
          if (step) begin
            state_d = next_fwd(state_q);
            advance = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Blank flag: toggles on each expiry in BLINK and is cleared in any other
  // mode, so leaving BLINK restores the light on the following edge.
  always_comb begin
    blank_d = blank_q;
    if (en) begin
      if (mode_s == MODE_BLINK) begin
        if (expire) begin
          blank_d = ~blank_q;
        end
      end else begin
        blank_d = 1'b0;
      end
    end
  end

  // Output values are computed from the next state so that light and
  // color_idx update on the same edge as the colour itself. wrap only fires
  // on a genuine move into RED, which never happens while frozen or blinking.
  always_comb begin
    color_idx_d = state_d;
    light_d     = blank_d ? 3'b000 : one_hot(state_d);
    wrap_d      = advance && (state_d == ST_RED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RED;
      cnt_q       <= '0;
      ps_q        <= '0;
      blank_q     <= 1'b0;
      light_q     <= 3'b100;
      color_idx_q <= 2'd0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ps_q        <= ps_d;
      blank_q     <= blank_d;
      light_q     <= light_d;
      color_idx_q <= color_idx_d;
      wrap_q      <= wrap_d;
    end
  end

  assign light     = light_q;
  assign color_idx = color_idx_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rgb_sequencer
//
// Purpose:
//   Self-checking bench for rgb_sequencer. Two instances share all inputs:
//   dut_p1 with PRESCALE=1 and dut_p4 with PRESCALE=4. A behavioural model
//   tracks colour, elapsed ticks, prescale phase and blank for each instance
//   with plain integer arithmetic. Directed scenario tasks also check fixed
//   expected sequences; a randomized task exercises everything together.
// -----------------------------------------------------------------------------
module tb_rgb_sequencer;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic             step;
  logic [CNT_W-1:0] dwell_r;
  logic [CNT_W-1:0] dwell_g;
  logic [CNT_W-1:0] dwell_b;

  logic [2:0] light_a, light_b;
  logic [1:0] idx_a, idx_b;
  logic       wrap_a, wrap_b;

  int vectors     = 0;
  int miscompares = 0;

  // Model state per instance: 0 = PRESCALE 1, 1 = PRESCALE 4
  int m_col   [2];
  int m_cnt   [2];
  int m_ps    [2];
  bit m_blank [2];
  bit m_wrap  [2];
  int limit;

  rgb_sequencer #(.CNT_W(CNT_W), .PRESCALE(1), .PS_W(8)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
    .dwell_r(dwell_r), .dwell_g(dwell_g), .dwell_b(dwell_b),
    .light(light_a), .color_idx(idx_a), .wrap(wrap_a)
  );

  rgb_sequencer #(.CNT_W(CNT_W), .PRESCALE(4), .PS_W(3)) dut_p4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step),
    .dwell_r(dwell_r), .dwell_g(dwell_g), .dwell_b(dwell_b),
    .light(light_b), .color_idx(idx_b), .wrap(wrap_b)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int prescale_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int dwell_of(input int c);
    case (c)
      0:       return int'(dwell_r);
      1:       return int'(dwell_g);
      default: return int'(dwell_b);
    endcase
  endfunction

  // Reference model: colour 0/1/2, elapsed ticks in the current dwell,
  // clock cycles into the current tick, and the blink blank flag.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          m_col[i] = 0; m_cnt[i] = 0; m_ps[i] = 0;
          m_blank[i] = 1'b0; m_wrap[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          m_wrap[i] = 1'b0;
          if (en) begin
            if (mode == 2'd2) begin
              m_cnt[i] = 0; m_ps[i] = 0; m_blank[i] = 1'b0;
              if (step) begin
                m_col[i]  = (m_col[i] + 1) % 3;
                m_wrap[i] = (m_col[i] == 0);
              end
            end else begin
              if (m_ps[i] == prescale_of(i) - 1) begin
                m_ps[i] = 0;
                limit = dwell_of(m_col[i]);
                if (limit == 0) limit = 1;
                if (m_cnt[i] + 1 >= limit) begin
                  m_cnt[i] = 0;
                  if (mode == 2'd0) begin
                    m_col[i]  = (m_col[i] + 1) % 3;
                    m_wrap[i] = (m_col[i] == 0);
                  end else if (mode == 2'd1) begin
                    m_col[i]  = (m_col[i] + 2) % 3;
                    m_wrap[i] = (m_col[i] == 0);
                  end else begin
                    m_blank[i] = !m_blank[i];
                  end
                end else begin
                  m_cnt[i] = m_cnt[i] + 1;
                end
              end else begin
                m_ps[i] = m_ps[i] + 1;
              end
              if (mode != 2'd3) m_blank[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Short async reset pulse released between clock edges; the caller
  // samples the reset state right after this returns.
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; mode = 2'd0; step = 1'b0;
    dwell_r = 8'd2; dwell_g = 8'd2; dwell_b = 8'd2;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({light_a, idx_a, wrap_a} !== {3'b100, 2'd0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL reset_p1 cyc=%0d got light=%b idx=%0d wrap=%b want 100/0/0",
                 k, light_a, idx_a, wrap_a);
      end
      vectors++;
      if ({light_b, idx_b, wrap_b} !== {3'b100, 2'd0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL reset_p4 cyc=%0d got light=%b idx=%0d wrap=%b want 100/0/0",
                 k, light_b, idx_b, wrap_b);
      end
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fwd();
    logic [2:0] exp_l;
    logic       exp_w;
    logic [2:0] obs_l;
    logic [1:0] obs_c;
    logic       obs_w;
    en = 1'b1; mode = 2'd0; step = 1'b0;
    dwell_r = 8'd2; dwell_g = 8'd3; dwell_b = 8'd1;
    pulse_reset();
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      case (k % 6)
        0, 1:    exp_l = 3'b100;
        2, 3, 4: exp_l = 3'b010;
        default: exp_l = 3'b001;
      endcase
      exp_w = (k % 6 == 0) && (k > 0);
      vectors++;
      if (light_a !== exp_l || wrap_a !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL fwd_seq k=%0d got light=%b wrap=%b want light=%b wrap=%b",
                 k, light_a, wrap_a, exp_l, exp_w);
      end
      for (int i = 0; i < 2; i++) begin
        obs_l = (i == 0) ? light_a : light_b;
        obs_c = (i == 0) ? idx_a : idx_b;
        obs_w = (i == 0) ? wrap_a : wrap_b;
        exp_l = m_blank[i] ? 3'b000 : 3'(3'b100 >> m_col[i]);
        vectors++;
        if ({obs_l, obs_c, obs_w} !== {exp_l, 2'(m_col[i]), m_wrap[i]}) begin
          miscompares++;
          $display("[TB] FAIL fwd_model inst=%0d k=%0d got %b/%0d/%b want %b/%0d/%b",
                   i, k, obs_l, obs_c, obs_w, exp_l, m_col[i], m_wrap[i]);
        end
      end
    end
  endtask

  task automatic test_rev_zero();
    logic [2:0] exp_l;
    logic       exp_w;
    en = 1'b1; mode = 2'd1; step = 1'b0;
    dwell_r = 8'd0; dwell_g = 8'd0; dwell_b = 8'd0;
    pulse_reset();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      case (k % 3)
        0:       exp_l = 3'b100;
        1:       exp_l = 3'b001;
        default: exp_l = 3'b010;
      endcase
      exp_w = (k % 3 == 0) && (k > 0);
      vectors++;
      if (light_a !== exp_l || wrap_a !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL rev_zero k=%0d got light=%b wrap=%b want light=%b wrap=%b",
                 k, light_a, wrap_a, exp_l, exp_w);
      end
      exp_l = m_blank[1] ? 3'b000 : 3'(3'b100 >> m_col[1]);
      vectors++;
      if ({light_b, idx_b, wrap_b} !== {exp_l, 2'(m_col[1]), m_wrap[1]}) begin
        miscompares++;
        $display("[TB] FAIL rev_model_p4 k=%0d got %b/%0d/%b want %b/%0d/%b",
                 k, light_b, idx_b, wrap_b, exp_l, m_col[1], m_wrap[1]);
      end
    end
  endtask

  task automatic test_step();
    logic [2:0] exp_seq [18] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                 3'b010, 3'b010, 3'b010, 3'b010,
                                 3'b001, 3'b001, 3'b001, 3'b001,
                                 3'b100, 3'b010, 3'b001, 3'b001};
    logic exp_w;
    en = 1'b1; mode = 2'd2; step = 1'b0;
    dwell_r = 8'd3; dwell_g = 8'd3; dwell_b = 8'd3;
    pulse_reset();
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      exp_w = (k == 14);
      vectors++;
      if (light_a !== exp_seq[k] || wrap_a !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL step_p1 k=%0d got light=%b wrap=%b want light=%b wrap=%b",
                 k, light_a, wrap_a, exp_seq[k], exp_w);
      end
      vectors++;
      if (light_b !== exp_seq[k] || wrap_b !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL step_p4 k=%0d got light=%b wrap=%b want light=%b wrap=%b",
                 k, light_b, wrap_b, exp_seq[k], exp_w);
      end
      step = (k == 5) || (k == 9) || (k == 13) || (k == 14) || (k == 15);
    end
    step = 1'b0;
  endtask

  task automatic test_blink_exit();
    logic [2:0] exp_l [10] = '{3'b100, 3'b010, 3'b010, 3'b000, 3'b000,
                               3'b010, 3'b010, 3'b000, 3'b010, 3'b001};
    logic [1:0] exp_c [10] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                               2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [2:0] mod_l;
    en = 1'b1; mode = 2'd0; step = 1'b0;
    dwell_r = 8'd1; dwell_g = 8'd2; dwell_b = 8'd1;
    pulse_reset();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (light_a !== exp_l[k] || idx_a !== exp_c[k] || wrap_a !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL blink_p1 k=%0d got light=%b idx=%0d wrap=%b want light=%b idx=%0d wrap=0",
                 k, light_a, idx_a, wrap_a, exp_l[k], exp_c[k]);
      end
      mod_l = m_blank[1] ? 3'b000 : 3'(3'b100 >> m_col[1]);
      vectors++;
      if ({light_b, idx_b, wrap_b} !== {mod_l, 2'(m_col[1]), m_wrap[1]}) begin
        miscompares++;
        $display("[TB] FAIL blink_model_p4 k=%0d got %b/%0d/%b want %b/%0d/%b",
                 k, light_b, idx_b, wrap_b, mod_l, m_col[1], m_wrap[1]);
      end
      if (k == 1) mode = 2'd3;
      if (k == 7) mode = 2'd0;
    end
  endtask

  task automatic test_freeze_shrink();
    logic [2:0] exp_l;
    en = 1'b1; mode = 2'd0; step = 1'b0;
    dwell_r = 8'd10; dwell_g = 8'd5; dwell_b = 8'd5;
    pulse_reset();
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      exp_l = (k == 13) ? 3'b010 : 3'b100;
      vectors++;
      if (light_a !== exp_l || wrap_a !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL freeze_p1 k=%0d got light=%b wrap=%b want light=%b wrap=0",
                 k, light_a, wrap_a, exp_l);
      end
      exp_l = m_blank[1] ? 3'b000 : 3'(3'b100 >> m_col[1]);
      vectors++;
      if ({light_b, idx_b, wrap_b} !== {exp_l, 2'(m_col[1]), m_wrap[1]}) begin
        miscompares++;
        $display("[TB] FAIL freeze_model_p4 k=%0d got %b/%0d/%b want %b/%0d/%b",
                 k, light_b, idx_b, wrap_b, exp_l, m_col[1], m_wrap[1]);
      end
      if (k == 4)  en = 1'b0;
      if (k == 11) en = 1'b1;
      if (k == 12) dwell_r = 8'd3;
    end
  endtask

  task automatic test_prescale_reset();
    logic [2:0] exp_l;
    logic       exp_w;
    en = 1'b1; mode = 2'd0; step = 1'b0;
    dwell_r = 8'd1; dwell_g = 8'd1; dwell_b = 8'd1;
    pulse_reset();
    for (int k = 0; k < 22; k++) begin
      if (k > 0) @(negedge clk);
      case ((k / 4) % 3)
        0:       exp_l = 3'b100;
        1:       exp_l = 3'b010;
        default: exp_l = 3'b001;
      endcase
      exp_w = (k % 12 == 0) && (k > 0);
      vectors++;
      if (light_b !== exp_l || wrap_b !== exp_w) begin
        miscompares++;
        $display("[TB] FAIL prescale_p4 k=%0d got light=%b wrap=%b want light=%b wrap=%b",
                 k, light_b, wrap_b, exp_l, exp_w);
      end
    end
    // Instance p4 is on BLUE here; drop reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({light_b, idx_b, wrap_b} !== {3'b100, 2'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset_p4 got light=%b idx=%0d wrap=%b want 100/0/0",
               light_b, idx_b, wrap_b);
    end
    vectors++;
    if ({light_a, idx_a, wrap_a} !== {3'b100, 2'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset_p1 got light=%b idx=%0d wrap=%b want 100/0/0",
               light_a, idx_a, wrap_a);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0] exp_l;
    logic [2:0] obs_l;
    logic [1:0] obs_c;
    logic       obs_w;
    en = 1'b1; mode = 2'd0; step = 1'b0;
    dwell_r = 8'd2; dwell_g = 8'd1; dwell_b = 8'd3;
    pulse_reset();
    for (int k = 0; k < 1500; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        obs_l = (i == 0) ? light_a : light_b;
        obs_c = (i == 0) ? idx_a : idx_b;
        obs_w = (i == 0) ? wrap_a : wrap_b;
        exp_l = m_blank[i] ? 3'b000 : 3'(3'b100 >> m_col[i]);
        vectors++;
        if ({obs_l, obs_c, obs_w} !== {exp_l, 2'(m_col[i]), m_wrap[i]}) begin
          miscompares++;
          $display("[TB] FAIL random inst=%0d k=%0d mode=%0d en=%b got %b/%0d/%b want %b/%0d/%b",
                   i, k, mode, en, obs_l, obs_c, obs_w, exp_l, m_col[i], m_wrap[i]);
        end
      end
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({light_a, idx_a, wrap_a, light_b, idx_b, wrap_b} !==
            {3'b100, 2'd0, 1'b0, 3'b100, 2'd0, 1'b0}) begin
          miscompares++;
          $display("[TB] FAIL random_reset k=%0d got %b/%0d/%b %b/%0d/%b want 100/0/0 both",
                   k, light_a, idx_a, wrap_a, light_b, idx_b, wrap_b);
        end
        rst_n = 1'b1;
      end
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) dwell_r = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) dwell_g = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) dwell_b = 8'($urandom_range(0, 4));
    end
  endtask

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout reached before end of tests");
    $fatal(1, "[TB] timeout");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_fwd();
    test_rev_zero();
    test_step();
    test_blink_exit();
    test_freeze_shrink();
    test_prescale_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rgb_sequencer.md
Name: rgb_sequencer

Overview:
Parametrised successor to the fixed 3-colour light cycler. Drives a one-hot R/G/B light output through programmable per-colour dwell times, counted in prescaled ticks. Four run modes: forward cycle, reverse cycle, manual step and blink. Also provides enable/freeze and a wrap pulse for chaining or display-refresh logic.

Parameters:
CNT_W, 8, width of dwell inputs and dwell counter
PRESCALE, 1, clk cycles per tick (>=1); PRESCALE=1 means one tick every clk
PS_W, 8, prescaler counter width; must satisfy 2^PS_W >= PRESCALE

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = run; 0 = freeze all state, outputs held
mode  input  2  0 FWD, 1 REV, 2 STEP, 3 BLINK
step  input  1  single-cycle advance request, used in STEP mode only
dwell_r  input  CNT_W  red dwell in ticks
dwell_g  input  CNT_W  green dwell in ticks
dwell_b  input  CNT_W  blue dwell in ticks
light  output  3  one-hot colour {R,G,B}: 100 red, 010 green, 001 blue, 000 blanked
color_idx  output  2  current colour: 0 R, 1 G, 2 B; 3 never produced
wrap  output  1  one-cycle pulse on entry to RED from a cycle transition

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, sync release): state RED, dwell cnt 0, prescaler 0, blank 0, light=100, color_idx=0, wrap=0.
- All outputs registered. light and color_idx change on the same edge as the state.
- Tick: prescaler counts 0..PRESCALE-1 while en=1 and mode!=STEP. Tick asserted when prescaler==PRESCALE-1. Prescaler wraps to 0 on tick. PRESCALE=1 gives a tick every cycle.
- Effective dwell D = selected dwell_x for the current colour, with 0 treated as 1. Dwell inputs are sampled live every cycle, not latched.
- Dwell expiry: on a tick with cnt >= D-1, expire and set cnt to 0. Otherwise cnt increments on tick. The >= rule means shrinking a dwell below the current cnt expires on the next tick.
- FWD: on expiry R->G->B->R.
- REV: on expiry R->B->G->R.
- Direction is evaluated at the expiry edge. A mode change mid-dwell keeps cnt.
- STEP: cnt and prescaler are forced to 0. When en=1 and step=1, advance forward one colour on that edge. step held high advances every cycle.
- BLINK:
  - Colour never changes.
  - On expiry, blank toggles.
  - light = blank ? 000 : one-hot(colour); color_idx is unaffected.
  - Leaving BLINK clears blank on the next edge, and light shows the colour.
- wrap: 1 for exactly the cycle after the edge that moves the state into RED by expiry or step (B->R in FWD/STEP, G->R in REV). It is 0 after reset and in BLINK.
- en=0: cnt, prescaler, state, blank and outputs are all held, and wrap=0. Resume continues from the held cnt.
- Reset mid-dwell or mid-blink returns immediately to reset values.
- mode and step are synchronous inputs and carry no internal synchronisation.

Test Plan:
- Reset/FWD: PRESCALE=1, en=1, mode=0, dwell_r=2, dwell_g=3, dwell_b=1, release rst_n -> light 100 for 2 cycles, 010 for 3, 001 for 1, then 100; wrap=1 for exactly one cycle at that return, repeats with period 6.
- REV + zero dwell: mode=1, all dwells=0 -> light sequence 100,001,010,100 changing every cycle; wrap pulses each time G->R occurs.
- STEP: mode=2, step pulsed 1 cycle at cycles 5 and 9 -> light 100→010 after first pulse, 010→001 after second; no change between pulses; step held high 3 cycles from BLUE gives 100,010,001 with wrap on first.
- BLINK + exit: mode=3 on GREEN, dwell_g=2 -> light 010,010,000,000,010...; switch mode=0 while blanked -> light returns 010 next edge, cnt continues.
- Freeze/shrink: FWD, dwell_r=10, drop en at cnt=4 for 7 cycles -> light held 100, wrap 0. Re-enable, then set dwell_r=3 -> RED expires on next tick (cnt>=2).
- Prescale + async reset: PRESCALE=4, dwells=1 -> colour changes every 4 clk. Assert rst_n low mid-cycle on BLUE -> light=100, color_idx=0, wrap=0 immediately, without a clock edge.
